// File: rtl/sha256_sched_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_sched_ctrl
//
// Front-end controller for a SHA-256 message scheduler. It gathers 16
// message words into a staging buffer, streams them to the scheduler with a
// 16-cycle load burst, and then sequences the 64 compression rounds. The
// next block may be collected while the current block is in its rounds, so
// blocks can run back-to-back at 80 cycles each.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   word_valid_i  message word valid
//   word_i        message word (word 0 first, big-endian word order)
//   first_i       block is the first of a message (sampled with word 0)
//   word_ready_o  word_i is accepted this cycle when word_valid_i is high
//   abort_i       synchronous flush, overrides everything else
//   ld_o          load strobe to the scheduler
//   M_o           word presented to the scheduler during load
//   rnd_valid_o   scheduler output W[t] is valid this cycle
//   rnd_idx_o     round index t
//   rnd_first_o   round t == 0
//   rnd_last_o    round t == 63
//   blk_first_o   block in its rounds is the first of its message
//   done_o        one-cycle pulse after the last round
//   busy_o        controller is not idle
// ----------------------------------------------------------------------------
module sha256_sched_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        word_valid_i,
   input  logic [31:0] word_i,
   input  logic        first_i,
   output logic        word_ready_o,
   input  logic        abort_i,
   output logic        ld_o,
   output logic [31:0] M_o,
   output logic        rnd_valid_o,
   output logic [5:0]  rnd_idx_o,
   output logic        rnd_first_o,
   output logic        rnd_last_o,
   output logic        blk_first_o,
   output logic        done_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2
   } state_e;

   localparam logic [5:0] LOAD_LAST  = 6'd15;
   localparam logic [5:0] ROUND_LAST = 6'd63;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;          // load index c in LOAD, round index t in ROUND
   logic [4:0]  wr_cnt_q, wr_cnt_d;    // words held in the staging buffer, 0..16
   logic        pend_first_q, pend_first_d;
   logic        blk_first_q, blk_first_d;
   logic        done_q, done_d;
   logic [31:0] stage_q [16];
   logic [31:0] stage_d [16];

   logic full;
   logic accept;

   assign full   = (wr_cnt_q == 5'd16);
   assign accept = word_valid_i && !full && !abort_i;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the values that existed before this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wr_cnt_q     <= '0;
         pend_first_q <= 1'b0;
         blk_first_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         pend_first_q <= pend_first_d;
         blk_first_q  <= blk_first_d;
         done_q       <= done_d;
      end
   end

   // NOTE: the staging buffer has no reset. Its contents only reach M_o
   // during LOAD, and LOAD requires all 16 entries to have been rewritten
   // since the last reset or abort, so stale data is never observable.
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath update
   // -------------------------------------------------------------------------
   // NOTE: every signal assigned here gets a default at the top so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_cnt_d     = wr_cnt_q;
      pend_first_d = pend_first_q;
      blk_first_d  = blk_first_q;
      done_d       = 1'b0;
      stage_d      = stage_q;

      // Word intake runs independently of the sequencer; it stalls only
      // when the buffer is full, which also holds it off during LOAD.
      if (accept) begin
         stage_d[wr_cnt_q[3:0]] = word_i;
         wr_cnt_d               = wr_cnt_q + 5'd1;
         if (wr_cnt_q == 5'd0) begin
            pend_first_d = first_i;
         end
      end

      case (state_q)
         IDLE: begin
            if (full) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               // Buffer has been handed to the scheduler: free it for the
               // next block and latch this block's first flag for the rounds.
               state_d     = ROUND;
               cnt_d       = '0;
               wr_cnt_d    = '0;
               blk_first_d = pend_first_q;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ROUND: begin
            if (cnt_q == ROUND_LAST) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = full ? LOAD : IDLE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Flush wins over intake, sequencing and the done pulse.
      if (abort_i) begin
         state_d      = IDLE;
         cnt_d        = '0;
         wr_cnt_d     = '0;
         pend_first_d = 1'b0;
         blk_first_d  = 1'b0;
         done_d       = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      word_ready_o = !full && !abort_i;
      ld_o         = 1'b0;
      M_o          = '0;
      rnd_valid_o  = 1'b0;
      rnd_idx_o    = '0;
      rnd_first_o  = 1'b0;
      rnd_last_o   = 1'b0;
      blk_first_o  = 1'b0;
      done_o       = done_q;
      busy_o       = (state_q != IDLE);

      case (state_q)
         LOAD: begin
            ld_o = 1'b1;
            M_o  = stage_q[cnt_q[3:0]];
         end
         ROUND: begin
            rnd_valid_o = 1'b1;
            rnd_idx_o   = cnt_q;
            rnd_first_o = (cnt_q == 6'd0);
            rnd_last_o  = (cnt_q == ROUND_LAST);
            blk_first_o = blk_first_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sha256_sched_ctrl
//
// Self-checking bench for sha256_sched_ctrl. A small behavioural message
// scheduler is attached to ld_o/M_o/rnd_valid_o so W[t] can be checked
// against known SHA-256 values for the "abc" block. Words are supplied from
// a feed queue that presents the head word each cycle and pops it when the
// DUT accepts it.
// ----------------------------------------------------------------------------
module tb_sha256_sched_ctrl;

   typedef logic [31:0] blk_t [16];

   typedef struct {
      logic [31:0] word;
      logic        first;
   } feed_t;

   typedef struct {
      logic        v;
      logic [31:0] w;
      logic        f;
      logic        a;
      logic        exp_ready;
      logic        exp_busy;
      logic        exp_ld;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        word_valid_i = 1'b0;
   logic [31:0] word_i = '0;
   logic        first_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        word_ready_o;
   logic        ld_o;
   logic [31:0] M_o;
   logic        rnd_valid_o;
   logic [5:0]  rnd_idx_o;
   logic        rnd_first_o;
   logic        rnd_last_o;
   logic        blk_first_o;
   logic        done_o;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   feed_t       feed_q[$];
   logic        rst_req   = 1'b0;
   logic        abort_req = 1'b0;
   logic        gap_en    = 1'b0;
   logic        man_valid = 1'b0;
   logic        man_first = 1'b0;
   logic [31:0] man_word  = '0;

   logic [31:0] sw [16];

   sha256_sched_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .word_valid_i (word_valid_i),
      .word_i       (word_i),
      .first_i      (first_i),
      .word_ready_o (word_ready_o),
      .abort_i      (abort_i),
      .ld_o         (ld_o),
      .M_o          (M_o),
      .rnd_valid_o  (rnd_valid_o),
      .rnd_idx_o    (rnd_idx_o),
      .rnd_first_o  (rnd_first_o),
      .rnd_last_o   (rnd_last_o),
      .blk_first_o  (blk_first_o),
      .done_o       (done_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // Reference message scheduler: 16-word window, W[t] is always sw[0].
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   always @(posedge clk) begin
      if (ld_o) begin
         for (int i = 0; i < 15; i++) sw[i] <= sw[i+1];
         sw[15] <= M_o;
      end else if (rnd_valid_o) begin
         for (int i = 0; i < 15; i++) sw[i] <= sw[i+1];
         sw[15] <= ssig1(sw[14]) + sw[9] + ssig0(sw[1]) + sw[0];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (time %0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: inputs change 1 time unit after the rising edge,
   // outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      rst_n   = rst_req;
      abort_i = abort_req;
      if (feed_q.size() != 0) begin
         word_valid_i = gap_en ? ($urandom_range(0, 1) == 1) : 1'b1;
         word_i       = feed_q[0].word;
         first_i      = feed_q[0].first;
      end else begin
         word_valid_i = man_valid;
         word_i       = man_word;
         first_i      = man_first;
      end
      @(negedge clk);
      if (feed_q.size() != 0 && word_valid_i && word_ready_o && rst_n)
         void'(feed_q.pop_front());
   endtask

   task automatic push_blk(input blk_t b, input logic f, input int n);
      feed_t e;
      for (int k = 0; k < n; k++) begin
         e.word  = b[k];
         e.first = (k == 0) ? f : 1'b0;
         feed_q.push_back(e);
      end
   endtask

   task automatic make_blk(input logic [31:0] base, output blk_t b);
      for (int k = 0; k < 16; k++) b[k] = base + 32'(k) * 32'h0101_0011;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, " word_ready_o"}, 32'(word_ready_o), 32'd1);
      check({tag, " ld_o"},         32'(ld_o),         32'd0);
      check({tag, " M_o"},          M_o,               32'd0);
      check({tag, " rnd_valid_o"},  32'(rnd_valid_o),  32'd0);
      check({tag, " rnd_idx_o"},    32'(rnd_idx_o),    32'd0);
      check({tag, " rnd_first_o"},  32'(rnd_first_o),  32'd0);
      check({tag, " rnd_last_o"},   32'(rnd_last_o),   32'd0);
      check({tag, " blk_first_o"},  32'(blk_first_o),  32'd0);
      check({tag, " done_o"},       32'(done_o),       32'd0);
      check({tag, " busy_o"},       32'(busy_o),       32'd0);
   endtask

   // Waits for LOAD, checks the 16 load cycles and the 64 round cycles, then
   // the done cycle. ready_until: rounds t < ready_until expect word_ready_o=1.
   // abort_t >= 0 asserts abort_i in round abort_t and stops after checking
   // the cycle that follows it.
   task automatic process_block(input blk_t m, input logic exp_bf, input int ready_until,
                                input bit chk_w, input int abort_t, input logic exp_next_ld);
      int n = 0;
      while (!ld_o && n < 300) begin
         step();
         n++;
      end
      check("load start", 32'(ld_o), 32'd1);
      if (!ld_o) return;

      for (int c = 0; c < 16; c++) begin
         check($sformatf("ld_o c=%0d", c), 32'(ld_o), 32'd1);
         check($sformatf("M_o c=%0d", c), M_o, m[c]);
         check($sformatf("ready in load c=%0d", c), 32'(word_ready_o), 32'd0);
         check($sformatf("rnd_valid in load c=%0d", c), 32'(rnd_valid_o), 32'd0);
         step();
      end

      for (int t = 0; t < 64; t++) begin
         check($sformatf("rnd_valid t=%0d", t), 32'(rnd_valid_o), 32'd1);
         check($sformatf("rnd_idx t=%0d", t), 32'(rnd_idx_o), 32'(t));
         check($sformatf("rnd_first t=%0d", t), 32'(rnd_first_o), 32'(t == 0));
         check($sformatf("rnd_last t=%0d", t), 32'(rnd_last_o), 32'(t == 63));
         check($sformatf("blk_first t=%0d", t), 32'(blk_first_o), 32'(exp_bf));
         check($sformatf("ld/M in round t=%0d", t), {31'(M_o != 0), ld_o}, 32'd0);
         check($sformatf("done in round t=%0d", t), 32'(done_o), 32'd0);
         check($sformatf("ready in round t=%0d", t), 32'(word_ready_o),
               32'(t < ready_until && t != abort_t));
         if (chk_w && t == 0)  check("W[0]",  sw[0], 32'h6162_6380);
         if (chk_w && t == 16) check("W[16]", sw[0], 32'h6162_6380);
         if (chk_w && t == 17) check("W[17]", sw[0], 32'h000F_0000);
         if (t + 1 == abort_t) abort_req = 1'b1;
         if (t == abort_t) begin
            abort_req = 1'b0;
            step();
            check("after abort busy_o",      32'(busy_o),      32'd0);
            check("after abort rnd_valid_o", 32'(rnd_valid_o), 32'd0);
            check("after abort done_o",      32'(done_o),      32'd0);
            check("after abort word_ready",  32'(word_ready_o), 32'd1);
            check("after abort ld_o",        32'(ld_o),        32'd0);
            return;
         end
         step();
      end

      check("done_o after t=63",   32'(done_o),      32'd1);
      check("rnd_valid in done",   32'(rnd_valid_o), 32'd0);
      check("ld_o in done cycle",  32'(ld_o),        32'(exp_next_ld));
      check("busy_o in done cycle", 32'(busy_o),     32'(exp_next_ld));
   endtask

   initial begin
      vec_t vecs[6];
      blk_t abc, b1, b2, b3, bx, bnext, bf, by, bz;
      int   n;

      // Idle-state vectors starting from reset: abort blocks intake and
      // flushes a partially received block.
      vecs[0] = '{v:1'b0, w:32'h0,         f:1'b0, a:1'b0, exp_ready:1'b1, exp_busy:1'b0, exp_ld:1'b0};
      vecs[1] = '{v:1'b1, w:32'hAAAA_0001, f:1'b1, a:1'b1, exp_ready:1'b0, exp_busy:1'b0, exp_ld:1'b0};
      vecs[2] = '{v:1'b1, w:32'hAAAA_0002, f:1'b1, a:1'b0, exp_ready:1'b1, exp_busy:1'b0, exp_ld:1'b0};
      vecs[3] = '{v:1'b0, w:32'h0,         f:1'b0, a:1'b0, exp_ready:1'b1, exp_busy:1'b0, exp_ld:1'b0};
      vecs[4] = '{v:1'b1, w:32'hAAAA_0003, f:1'b0, a:1'b1, exp_ready:1'b0, exp_busy:1'b0, exp_ld:1'b0};
      vecs[5] = '{v:1'b0, w:32'h0,         f:1'b0, a:1'b0, exp_ready:1'b1, exp_busy:1'b0, exp_ld:1'b0};

      for (int k = 0; k < 16; k++) abc[k] = 32'h0;
      abc[0]  = 32'h6162_6380;
      abc[15] = 32'h0000_0018;
      make_blk(32'h1000_0000, b1);
      make_blk(32'h2000_0005, b2);
      make_blk(32'h3000_000A, b3);
      make_blk(32'h4000_0000, bx);
      make_blk(32'h5000_0000, bnext);
      make_blk(32'h6000_0003, bf);
      make_blk(32'h7000_0007, by);
      make_blk(32'h8000_0009, bz);

      // Reset
      rst_req = 1'b0;
      step();
      step();
      rst_req = 1'b1;
      step();
      check_reset_outs("reset");

      // Table-driven idle vectors
      for (int i = 0; i < 6; i++) begin
         man_valid = vecs[i].v;
         man_word  = vecs[i].w;
         man_first = vecs[i].f;
         abort_req = vecs[i].a;
         step();
         check($sformatf("vec%0d word_ready_o", i), 32'(word_ready_o), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d busy_o", i),       32'(busy_o),       32'(vecs[i].exp_busy));
         check($sformatf("vec%0d ld_o", i),         32'(ld_o),         32'(vecs[i].exp_ld));
         check($sformatf("vec%0d done_o", i),       32'(done_o),       32'd0);
      end
      man_valid = 1'b0;
      abort_req = 1'b0;

      // "abc" block: exact latency from the 16th word to LOAD, W checks
      push_blk(abc, 1'b1, 16);
      for (int k = 0; k < 16; k++) step();
      check("abc all words taken", 32'(feed_q.size()), 32'd0);
      step();
      check("abc ld_o before load",  32'(ld_o),         32'd0);
      check("abc ready while full",  32'(word_ready_o), 32'd0);
      check("abc busy before load",  32'(busy_o),       32'd0);
      step();
      check("abc load begins", 32'(ld_o), 32'd1);
      process_block(abc, 1'b1, 64, 1'b1, -1, 1'b0);
      check("abc ready after done", 32'(word_ready_o), 32'd1);
      step();
      check("abc done_o one cycle", 32'(done_o), 32'd0);

      // Back-to-back: block 2 arrives during block 1's rounds
      push_blk(b1, 1'b1, 16);
      push_blk(b2, 1'b0, 16);
      process_block(b1, 1'b1, 16, 1'b0, -1, 1'b1);
      process_block(b2, 1'b0, 64, 1'b0, -1, 1'b0);

      // Random valid gaps: no LOAD while words are still pending
      push_blk(b3, 1'b1, 16);
      gap_en = 1'b1;
      n = 0;
      while (feed_q.size() != 0 && n < 400) begin
         step();
         n++;
         if (feed_q.size() != 0) check("gap no early load", 32'(ld_o), 32'd0);
      end
      check("gap words delivered", 32'(feed_q.size()), 32'd0);
      gap_en = 1'b0;
      process_block(b3, 1'b1, 64, 1'b0, -1, 1'b0);
      step();
      check("gap done_o one cycle", 32'(done_o), 32'd0);

      // Abort at round 30 with 5 words of the next block buffered
      push_blk(bx, 1'b1, 16);
      push_blk(bnext, 1'b1, 5);
      process_block(bx, 1'b1, 64, 1'b0, 30, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("post-abort done_o %0d", k), 32'(done_o), 32'd0);
         check($sformatf("post-abort ld_o %0d", k),   32'(ld_o),   32'd0);
      end
      push_blk(bf, 1'b0, 16);
      process_block(bf, 1'b0, 64, 1'b0, -1, 1'b0);

      // Reset at LOAD c=7, then a normal block
      push_blk(by, 1'b1, 16);
      n = 0;
      while (!ld_o && n < 300) begin
         step();
         n++;
      end
      check("rst test load start", 32'(ld_o), 32'd1);
      for (int c = 0; c < 7; c++) begin
         check($sformatf("rst test M_o c=%0d", c), M_o, by[c]);
         if (c == 6) rst_req = 1'b0;
         step();
      end
      check("rst test M_o c=7", M_o, by[7]);
      rst_req = 1'b1;
      step();
      check_reset_outs("mid-load reset");
      push_blk(bz, 1'b0, 16);
      process_block(bz, 1'b0, 64, 1'b0, -1, 1'b0);
      step();
      check("final done_o one cycle", 32'(done_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
